// File: rtl/scaler_div_arbiter_pkg.sv
// ============================================================================
// Module  : scaler_div_arbiter_pkg
// Brief   : Shared video-scaler parameters: FSM encodings, grant side, constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package scaler_div_arbiter_pkg;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_launch = 2'd1;
    localparam logic [1:0] c_st_wait   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    typedef enum logic {
        SEL_V = 1'b0,
        SEL_H = 1'b1
    } sel_e;

    // Dividend is a single one in the MSB position: 2^(width-1)
    function automatic logic [31:0] fixed_dividend(input int width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic logic [31:0] err_quot(input int width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/scaler_div_arbiter_if.sv
// ============================================================================
// Module  : scaler_div_arbiter_if
// Brief   : Requester-side bundle for the vertical and horizontal scaler ports
// Revision: 1.0
// ============================================================================
`default_nettype none

interface scaler_div_arbiter_if #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12
);
    logic                      v_req_i;
    logic [10:0]               v_divisor_i;
    logic [DIVIDEND_WIDTH-1:0] v_quot_o;
    logic                      v_done_o;
    logic                      v_busy_o;

    logic                      h_req_i;
    logic [DIVISOR_WIDTH-1:0]  h_divisor_i;
    logic [DIVIDEND_WIDTH-1:0] h_quot_o;
    logic                      h_done_o;
    logic                      h_busy_o;

    logic                      err_o;

    modport master (
        output v_req_i, v_divisor_i, h_req_i, h_divisor_i,
        input  v_quot_o, v_done_o, v_busy_o, h_quot_o, h_done_o, h_busy_o, err_o
    );

    modport slave (
        input  v_req_i, v_divisor_i, h_req_i, h_divisor_i,
        output v_quot_o, v_done_o, v_busy_o, h_quot_o, h_done_o, h_busy_o, err_o
    );
endinterface

`default_nettype wire

// File: rtl/scaler_div_arbiter_serial_divide.sv
// ============================================================================
// Module  : serial_divide
// Brief   : Restoring serial divider, one quotient bit per cycle, done pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_divide #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12
) (
    input  logic                      clk_i,
    input  logic                      nrst_i,
    input  logic                      cmd_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic [DIVIDEND_WIDTH-1:0] quot_o,
    output logic                      done_o
);

    localparam int c_cnt_w = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  r_rem;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic [DIVIDEND_WIDTH-1:0] r_dq;
    logic [c_cnt_w-1:0]        r_cnt;
    logic                      r_done;

    logic [DIVISOR_WIDTH:0]    w_shift;
    logic [DIVISOR_WIDTH-1:0]  w_diff;
    logic                      w_fits;

    // r_dq shifts dividend bits out at the top and quotient bits in at the bottom
    assign w_shift = {r_rem, r_dq[DIVIDEND_WIDTH-1]};
    assign w_fits  = (w_shift >= {1'b0, r_divisor});
    assign w_diff  = DIVISOR_WIDTH'(w_shift - {1'b0, r_divisor});

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            r_rem     <= '0;
            r_divisor <= '0;
            r_dq      <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (cmd_i) begin
                r_rem     <= '0;
                r_dq      <= dividend_i;
                r_divisor <= divisor_i;
                r_cnt     <= c_cnt_w'(DIVIDEND_WIDTH);
            end else if (r_cnt != '0) begin
                r_rem <= w_fits ? w_diff : w_shift[DIVISOR_WIDTH-1:0];
                r_dq  <= {r_dq[DIVIDEND_WIDTH-2:0], w_fits};
                r_cnt <= r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quot_o = r_dq;
    assign done_o = r_done;

endmodule

`default_nettype wire

// File: rtl/scaler_div_arbiter.sv
// ============================================================================
// Module  : scaler_div_arbiter
// Brief   : Round-robin arbiter sharing one serial divider between V and H scalers
// Revision: 1.0
// ============================================================================
`default_nettype none

module scaler_div_arbiter
    import scaler_div_arbiter_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12,
    parameter int WDOG_CYCLES    = 31
) (
    input  logic                 SYS_CLK,
    input  logic                 nRST,
    scaler_div_arbiter_if.slave  bus
);

    localparam int c_wdog_w = $clog2(WDOG_CYCLES + 1);
    localparam logic [DIVIDEND_WIDTH-1:0] c_dividend = DIVIDEND_WIDTH'(fixed_dividend(DIVIDEND_WIDTH));
    localparam logic [DIVIDEND_WIDTH-1:0] c_err_quot = DIVIDEND_WIDTH'(err_quot(DIVIDEND_WIDTH));

    logic [1:0]                r_state;
    sel_e                      r_sel;
    sel_e                      r_last;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic                      r_div_cmd;
    logic [c_wdog_w-1:0]       r_wdog;
    logic                      r_err;
    logic                      r_dropped;
    logic [DIVIDEND_WIDTH-1:0] r_result;
    logic [DIVIDEND_WIDTH-1:0] r_v_quot;
    logic [DIVIDEND_WIDTH-1:0] r_h_quot;

    logic                      w_grant_v;
    logic [DIVISOR_WIDTH-1:0]  w_grant_divisor;
    logic                      w_sel_req;
    logic                      w_deliver;
    logic                      w_div_done;
    logic [DIVIDEND_WIDTH-1:0] w_div_quot;

    // V wins unless H is also asking and V was the one served last
    assign w_grant_v       = bus.v_req_i && (!bus.h_req_i || (r_last == SEL_H));
    assign w_grant_divisor = w_grant_v
                           ? {{(DIVISOR_WIDTH-11){1'b0}}, bus.v_divisor_i}
                           : bus.h_divisor_i;
    assign w_sel_req       = (r_sel == SEL_V) ? bus.v_req_i : bus.h_req_i;

    serial_divide #(
        .DIVIDEND_WIDTH (DIVIDEND_WIDTH),
        .DIVISOR_WIDTH  (DIVISOR_WIDTH)
    ) u_div (
        .clk_i      (SYS_CLK),
        .nrst_i     (nRST),
        .cmd_i      (r_div_cmd),
        .dividend_i (c_dividend),
        .divisor_i  (r_divisor),
        .quot_o     (w_div_quot),
        .done_o     (w_div_done)
    );

    always_ff @(posedge SYS_CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= c_st_idle;
            r_sel     <= SEL_V;
            r_last    <= SEL_H;
            r_divisor <= '0;
            r_div_cmd <= 1'b0;
            r_wdog    <= '0;
            r_err     <= 1'b0;
            r_dropped <= 1'b0;
            r_result  <= '0;
            r_v_quot  <= '0;
            r_h_quot  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.v_req_i || bus.h_req_i) begin
                        r_sel     <= w_grant_v ? SEL_V : SEL_H;
                        r_last    <= w_grant_v ? SEL_V : SEL_H;
                        r_divisor <= w_grant_divisor;
                        r_div_cmd <= (w_grant_divisor != '0);
                        r_err     <= 1'b0;
                        r_dropped <= 1'b0;
                        r_wdog    <= '0;
                        r_state   <= c_st_launch;
                    end
                end
                c_st_launch: begin
                    r_div_cmd <= 1'b0;
                    if (!w_sel_req) begin
                        r_dropped <= 1'b1;
                    end
                    if (r_divisor == '0) begin
                        r_result <= c_err_quot;
                        r_err    <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_state  <= c_st_wait;
                    end
                end
                c_st_wait: begin
                    if (!w_sel_req) begin
                        r_dropped <= 1'b1;
                    end
                    if (w_div_done) begin
                        r_result <= w_div_quot;
                        r_state  <= c_st_done;
                    end else if (r_wdog == c_wdog_w'(WDOG_CYCLES - 1)) begin
                        r_result <= c_err_quot;
                        r_err    <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_wdog   <= r_wdog + c_wdog_w'(1);
                    end
                end
                c_st_done: begin
                    if (!r_dropped) begin
                        if (r_sel == SEL_V) begin
                            r_v_quot <= r_result;
                        end else begin
                            r_h_quot <= r_result;
                        end
                    end
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Result is shown combinationally in the DONE cycle so quot is valid with done
    assign w_deliver    = (r_state == c_st_done) && !r_dropped;
    assign bus.v_done_o = w_deliver && (r_sel == SEL_V);
    assign bus.h_done_o = w_deliver && (r_sel == SEL_H);
    assign bus.err_o    = w_deliver && r_err;
    assign bus.v_quot_o = bus.v_done_o ? r_result : r_v_quot;
    assign bus.h_quot_o = bus.h_done_o ? r_result : r_h_quot;
    assign bus.v_busy_o = (r_state != c_st_idle) && (r_sel == SEL_V);
    assign bus.h_busy_o = (r_state != c_st_idle) && (r_sel == SEL_H);

endmodule

`default_nettype wire

// File: tb/tb_scaler_div_arbiter.sv
// ============================================================================
// Module  : tb_scaler_div_arbiter
// Brief   : Scoreboard bench for the shared-divider scaler arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scaler_div_arbiter;
    import scaler_div_arbiter_pkg::*;

    localparam int DW = 18;
    localparam int VW = 12;

    typedef struct packed {
        logic [DW-1:0] quot;
        logic          err;
    } exp_t;

    logic SYS_CLK = 1'b0;
    logic nRST    = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    scaler_div_arbiter_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus  ();
    scaler_div_arbiter_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus2 ();

    scaler_div_arbiter #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .WDOG_CYCLES(31)) dut (
        .SYS_CLK (SYS_CLK),
        .nRST    (nRST),
        .bus     (bus)
    );

    // Short watchdog instance: the divider needs more than 8 WAIT cycles
    scaler_div_arbiter #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW), .WDOG_CYCLES(8)) dut2 (
        .SYS_CLK (SYS_CLK),
        .nRST    (nRST),
        .bus     (bus2)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   cmd_cnt  = 0;
    int   both_busy = 0;
    int   v_done_cnt = 0;
    int   h_done_cnt = 0;
    int   last_div_done_cyc = -100;
    exp_t v_sb[$];
    exp_t h_sb[$];

    always @(posedge SYS_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input int d);
        exp_t e;
        if (d == 0) begin
            e.quot = '1;
            e.err  = 1'b1;
        end else begin
            e.quot = DW'((32'd1 << (DW - 1)) / d);
            e.err  = 1'b0;
        end
        return e;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge SYS_CLK);
            if (nRST) begin
                if (dut.r_div_cmd) cmd_cnt++;
                if (dut.w_div_done) last_div_done_cyc = cyc;
                if (bus.v_busy_o && bus.h_busy_o) both_busy++;
                if (bus.v_done_o) begin
                    v_done_cnt++;
                    if (v_sb.size() == 0) check("v_done_unexpected", 1, 0);
                    else begin
                        e = v_sb.pop_front();
                        check("v_quot", 32'(bus.v_quot_o), 32'(e.quot));
                        check("v_err", 32'(bus.err_o), 32'(e.err));
                    end
                end
                if (bus.h_done_o) begin
                    h_done_cnt++;
                    if (h_sb.size() == 0) check("h_done_unexpected", 1, 0);
                    else begin
                        e = h_sb.pop_front();
                        check("h_quot", 32'(bus.h_quot_o), 32'(e.quot));
                        check("h_err", 32'(bus.err_o), 32'(e.err));
                    end
                end
            end
        end
    end

    task automatic wait_done(input bit is_h, output int done_cyc);
        done_cyc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge SYS_CLK);
            if (is_h ? bus.h_done_o : bus.v_done_o) begin
                done_cyc = cyc;
                break;
            end
        end
        if (done_cyc < 0) check(is_h ? "h_timeout" : "v_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        nRST = 1'b1;
        @(negedge SYS_CLK);
    endtask

    initial begin : stim
        int dv, dh, rc, c0;
        logic [DW-1:0] q2;
        logic e2;
        logic [3:0] seq;

        bus.v_req_i = 1'b0;  bus.v_divisor_i = '0;
        bus.h_req_i = 1'b0;  bus.h_divisor_i = '0;
        bus2.v_req_i = 1'b0; bus2.v_divisor_i = '0;
        bus2.h_req_i = 1'b0; bus2.h_divisor_i = '0;

        repeat (3) @(negedge SYS_CLK);
        check("rst_v_quot", 32'(bus.v_quot_o), 0);
        check("rst_h_quot", 32'(bus.h_quot_o), 0);
        check("rst_ctrl", {27'd0, bus.v_done_o, bus.v_busy_o, bus.h_done_o, bus.h_busy_o, bus.err_o}, 0);
        nRST = 1'b1;
        @(negedge SYS_CLK);

        // V alone, divisor 1080
        bus.v_divisor_i = 11'd1080;
        bus.v_req_i = 1'b1;
        v_sb.push_back(model(1080));
        wait_done(0, dv);
        bus.v_req_i = 1'b0;
        check("t1_latency", 32'(dv - last_div_done_cyc), 1);
        repeat (2) @(negedge SYS_CLK);
        check("t1_v_cnt", 32'(v_done_cnt), 1);
        check("t1_h_idle", 32'(h_done_cnt), 0);

        // Simultaneous requests right after reset: V first, then H
        pulse_reset();
        bus.v_divisor_i = 11'd720;
        bus.h_divisor_i = 12'd1920;
        bus.v_req_i = 1'b1;
        bus.h_req_i = 1'b1;
        v_sb.push_back(model(720));
        h_sb.push_back(model(1920));
        wait_done(0, dv);
        bus.v_req_i = 1'b0;
        wait_done(1, dh);
        bus.h_req_i = 1'b0;
        check("t2_order", 32'(dv < dh), 1);
        check("t2_no_overlap", 32'(both_busy), 0);

        // Zero divisor on H: no launch, error result two cycles after grant
        @(negedge SYS_CLK);
        c0 = cmd_cnt;
        bus.h_divisor_i = '0;
        bus.h_req_i = 1'b1;
        rc = cyc;
        h_sb.push_back(model(0));
        wait_done(1, dh);
        bus.h_req_i = 1'b0;
        check("t3_latency", 32'(dh - rc), 2);
        check("t3_no_cmd", 32'(cmd_cnt - c0), 0);
        @(negedge SYS_CLK);
        check("t3_err_pulse", 32'(bus.err_o), 0);

        // V drops mid-WAIT: result discarded, pending H served next
        @(negedge SYS_CLK);
        bus.v_divisor_i = 11'd500;
        bus.v_req_i = 1'b1;
        @(negedge SYS_CLK);
        bus.h_divisor_i = 12'd1000;
        bus.h_req_i = 1'b1;
        h_sb.push_back(model(1000));
        repeat (6) @(negedge SYS_CLK);
        check("t4_v_busy", 32'(bus.v_busy_o), 1);
        check("t4_h_not_busy", 32'(bus.h_busy_o), 0);
        bus.v_req_i = 1'b0;
        wait_done(1, dh);
        bus.h_req_i = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        check("t4_v_cnt", 32'(v_done_cnt), 2);
        check("t4_v_quot_kept", 32'(bus.v_quot_o), 182);

        // Reset during WAIT, then a fresh V job
        bus.v_divisor_i = 11'd300;
        bus.v_req_i = 1'b1;
        repeat (6) @(negedge SYS_CLK);
        check("t5_busy_before", 32'(bus.v_busy_o), 1);
        nRST = 1'b0;
        #1;
        check("t5_rst_v_quot", 32'(bus.v_quot_o), 0);
        check("t5_rst_h_quot", 32'(bus.h_quot_o), 0);
        check("t5_rst_ctrl", {27'd0, bus.v_done_o, bus.v_busy_o, bus.h_done_o, bus.h_busy_o, bus.err_o}, 0);
        v_sb.push_back(model(300));
        @(negedge SYS_CLK);
        nRST = 1'b1;
        wait_done(0, dv);
        bus.v_req_i = 1'b0;

        // Watchdog abort on the short-timeout instance
        @(negedge SYS_CLK);
        bus2.v_divisor_i = 11'd7;
        bus2.v_req_i = 1'b1;
        rc = cyc;
        dv = -1;
        q2 = '0;
        e2 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge SYS_CLK);
            if (bus2.v_done_o) begin
                dv = cyc;
                q2 = bus2.v_quot_o;
                e2 = bus2.err_o;
                break;
            end
        end
        bus2.v_req_i = 1'b0;
        check("t6_latency", 32'(dv - rc), 10);
        check("t6_quot", 32'(q2), 32'h3FFFF);
        check("t6_err", 32'(e2), 1);
        @(negedge SYS_CLK);
        check("t6_idle", 32'(dut2.r_state), 32'(c_st_idle));
        check("t6_quot_held", 32'(bus2.v_quot_o), 32'h3FFFF);

        // Both held continuously: service alternates, H first (V served last)
        @(negedge SYS_CLK);
        bus.v_divisor_i = 11'd100;
        bus.h_divisor_i = 12'd200;
        v_sb.push_back(model(100));
        v_sb.push_back(model(100));
        h_sb.push_back(model(200));
        h_sb.push_back(model(200));
        bus.v_req_i = 1'b1;
        bus.h_req_i = 1'b1;
        seq = '0;
        c0 = 0;
        for (int i = 0; i < 400 && c0 < 4; i++) begin
            @(negedge SYS_CLK);
            if (bus.v_done_o || bus.h_done_o) begin
                seq = {seq[2:0], bus.h_done_o};
                c0++;
            end
        end
        bus.v_req_i = 1'b0;
        bus.h_req_i = 1'b0;
        check("t7_alternate", 32'(seq), 32'b1010);
        repeat (3) @(negedge SYS_CLK);
        check("sb_empty", 32'(v_sb.size() + h_sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
